// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB for a shared
// single-ALU, single-memory datapath, with memory timeout and retire counter.
module uc_multiciclo #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [5:0]       opcode,
  output logic             instr_ready,
  input  logic             mem_ready,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemToWrite,
  output logic             MemRead,
  output logic [2:0]       ALUOp,
  output logic             busy,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;
  localparam logic [5:0] OP_JUMP  = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

  state_t     state, stateNext;
  logic [5:0] opQ, opNext;
  logic [7:0] waitCnt, waitNext;
  logic       retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      opQ     <= '0;
      waitCnt <= '0;
      retired <= '0;
    end else begin
      state   <= stateNext;
      opQ     <= opNext;
      waitCnt <= waitNext;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Outputs are forced to their idle values while rst is high, whatever the state.
  always_comb begin
    stateNext   = state;
    opNext      = opQ;
    waitNext    = waitCnt;
    retire      = 1'b0;
    instr_ready = 1'b0;
    busy        = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    MemToWrite  = 1'b0;
    MemRead     = 1'b0;
    ALUOp       = 3'b100;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (!rst) begin
      busy = (state != FETCH);
      case (state)
        FETCH: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            opNext    = opcode;
            stateNext = DECODE;
          end
        end
        DECODE: begin
          case (opQ)
            OP_RTYPE, OP_LOAD, OP_STORE, OP_JUMP, OP_ADDI: stateNext = EXEC;
            default: begin
              illegal_op = 1'b1;
              stateNext  = FETCH;
            end
          endcase
        end
        EXEC: begin
          case (opQ)
            OP_RTYPE: begin
              ALUOp     = 3'b000;
              stateNext = WB;
            end
            OP_LOAD, OP_STORE: begin
              ALUOp     = 3'b000;
              stateNext = MEM;
              waitNext  = 8'd1;
            end
            OP_JUMP: begin
              ALUOp     = 3'b010;
              stateNext = FETCH;
              retire    = 1'b1;
            end
            OP_ADDI: begin
              ALUOp     = 3'b100;
              stateNext = FETCH;
              retire    = 1'b1;
            end
            default: stateNext = FETCH;
          endcase
        end
        // mem_ready wins over the timeout when both happen in the same cycle.
        MEM: begin
          ALUOp      = 3'b000;
          MemRead    = (opQ == OP_LOAD);
          MemToWrite = (opQ == OP_STORE);
          if (mem_ready) begin
            if (opQ == OP_LOAD) begin
              stateNext = WB;
            end else begin
              stateNext = FETCH;
              retire    = 1'b1;
            end
          end else if (waitCnt == TIMEOUT) begin
            mem_timeout = 1'b1;
            stateNext   = FETCH;
          end else begin
            waitNext = waitCnt + 8'd1;
          end
        end
        WB: begin
          RegWrite  = 1'b1;
          MemToReg  = (opQ == OP_RTYPE);
          stateNext = FETCH;
          retire    = 1'b1;
        end
        default: stateNext = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: per-instruction expected output traces
// are built from the instruction-level timing rules and compared every cycle.
module tb_uc_multiciclo;

  localparam int MEM_TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        instr_ready, MemToReg, RegWrite, MemToWrite, MemRead, busy, illegal_op, mem_timeout;
  logic [2:0]  ALUOp;
  logic [15:0] retired;
  logic        sReady, sM2R, sRegW, sMemW, sMemR, sBusy, sIll, sTo;
  logic [2:0]  sAlu;
  logic [1:0]  retiredSmall;

  always #5 clk = ~clk;

  uc_multiciclo #(.CNT_W(16), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .MemToWrite(MemToWrite), .MemRead(MemRead), .ALUOp(ALUOp),
    .busy(busy), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .retired(retired)
  );

  uc_multiciclo #(.CNT_W(2), .MEM_TIMEOUT(MEM_TO)) dutSmall (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(sReady), .mem_ready(mem_ready), .MemToReg(sM2R),
    .RegWrite(sRegW), .MemToWrite(sMemW), .MemRead(sMemR), .ALUOp(sAlu),
    .busy(sBusy), .illegal_op(sIll), .mem_timeout(sTo), .retired(retiredSmall)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic        memRdy;
    logic [5:0]  op;
    logic [10:0] exp;
    bit          retire;
    bit          clr;
  } step_t;

  step_t       trace[$];
  logic [31:0] modelCnt = '0;
  int          checks = 0;
  int          errors = 0;
  logic [10:0] obs;
  logic [15:0] ret;
  logic [1:0]  ret2;

  // Output vector layout: {ready, busy, rd, wr, regw, m2r, illegal, timeout, alu}
  function automatic logic [10:0] mk(logic rdy, logic bsy, logic rd, logic wr, logic rw,
                                     logic m2r, logic ill, logic to, logic [2:0] alu);
    return {rdy, bsy, rd, wr, rw, m2r, ill, to, alu};
  endfunction

  function automatic void push(logic valid, logic [5:0] op, logic memRdy, logic [10:0] exp, bit retire);
    step_t s;
    s.rst = 1'b0; s.valid = valid; s.op = op; s.memRdy = memRdy;
    s.exp = exp; s.retire = retire; s.clr = 1'b0;
    trace.push_back(s);
  endfunction

  function automatic void addIdle();
    push(1'b0, 6'($urandom), 1'($urandom), mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b100), 1'b0);
  endfunction

  function automatic void addReset();
    step_t s;
    s.rst = 1'b1; s.valid = 1'($urandom); s.op = 6'($urandom); s.memRdy = 1'($urandom);
    s.exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b100); s.retire = 1'b0; s.clr = 1'b1;
    trace.push_back(s);
  endfunction

  // One instruction from its handshake cycle; delay = MEM cycles before mem_ready (<0: never).
  function automatic void addInstr(logic [5:0] op, int delay);
    bit legal = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd2) || (op == 6'd8);
    bit isLoad = (op == 6'd35);
    logic [2:0] alu;
    push(1'b1, op, 1'($urandom), mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b100), 1'b0);
    push(1'($urandom), 6'($urandom), 1'($urandom), mk(0, 1, 0, 0, 0, 0, !legal, 0, 3'b100), 1'b0);
    if (!legal) return;
    alu = (op == 6'd2) ? 3'b010 : (op == 6'd8) ? 3'b100 : 3'b000;
    push(1'($urandom), 6'($urandom), 1'($urandom), mk(0, 1, 0, 0, 0, 0, 0, 0, alu),
         (op == 6'd2) || (op == 6'd8));
    if (op == 6'd2 || op == 6'd8) return;
    if (op == 6'd0) begin
      push(1'($urandom), 6'($urandom), 1'($urandom), mk(0, 1, 0, 0, 1, 1, 0, 0, 3'b100), 1'b1);
      return;
    end
    for (int k = 0; k < 300; k++) begin
      bit rdyNow = (delay >= 0) && (k == delay);
      bit to = !rdyNow && (k + 1 == MEM_TO);
      push(1'($urandom), 6'($urandom), rdyNow, mk(0, 1, isLoad, !isLoad, 0, 0, 0, to, 3'b000),
           rdyNow && !isLoad);
      if (rdyNow && isLoad)
        push(1'($urandom), 6'($urandom), 1'($urandom), mk(0, 1, 0, 0, 1, 0, 0, 0, 3'b100), 1'b1);
      if (rdyNow || to) break;
    end
  endfunction

  task automatic stepDut(input step_t s, output logic [10:0] o, output logic [15:0] r, output logic [1:0] r2);
    @(negedge clk);
    rst = s.rst; instr_valid = s.valid; opcode = s.op; mem_ready = s.memRdy;
    #1;
    o  = {instr_ready, busy, MemRead, MemToWrite, RegWrite, MemToReg, illegal_op, mem_timeout, ALUOp};
    r  = retired;
    r2 = retiredSmall;
  endtask

  task automatic test_reset();
    trace.delete();
    addReset(); addReset(); addIdle();
    foreach (trace[i]) begin
      stepDut(trace[i], obs, ret, ret2);
      checks++;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("[TB] FAIL reset step %0d outputs: got %b expected %b", i, obs, trace[i].exp);
      end
      if (i > 0) begin
        checks++;
        if (ret !== 16'd0 || ret2 !== 2'd0) begin
          errors++;
          $display("[TB] FAIL reset step %0d retired: got %0d/%0d expected 0/0", i, ret, ret2);
        end
      end
    end
    modelCnt = 0;
  endtask

  task automatic test_rtype();
    trace.delete();
    addInstr(6'b000000, 0); addIdle();
    foreach (trace[i]) begin
      stepDut(trace[i], obs, ret, ret2);
      checks += 2;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("[TB] FAIL rtype step %0d outputs: got %b expected %b", i, obs, trace[i].exp);
      end
      if (ret !== modelCnt[15:0] || ret2 !== modelCnt[1:0]) begin
        errors++;
        $display("[TB] FAIL rtype step %0d retired: got %0d/%0d expected %0d", i, ret, ret2, modelCnt);
      end
      if (trace[i].clr) modelCnt = 0; else if (trace[i].retire) modelCnt++;
    end
  endtask

  task automatic test_mem();
    trace.delete();
    addInstr(6'b100011, 2);
    addInstr(6'b101011, -1);
    addInstr(6'b101011, MEM_TO - 1);
    addInstr(6'b100011, -1);
    addInstr(6'b100011, MEM_TO - 1);
    addIdle();
    foreach (trace[i]) begin
      stepDut(trace[i], obs, ret, ret2);
      checks += 2;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("[TB] FAIL mem step %0d outputs: got %b expected %b", i, obs, trace[i].exp);
      end
      if (ret !== modelCnt[15:0] || ret2 !== modelCnt[1:0]) begin
        errors++;
        $display("[TB] FAIL mem step %0d retired: got %0d/%0d expected %0d", i, ret, ret2, modelCnt);
      end
      if (trace[i].clr) modelCnt = 0; else if (trace[i].retire) modelCnt++;
    end
  endtask

  task automatic test_alu_illegal();
    trace.delete();
    addInstr(6'b000010, 0);
    addInstr(6'b001000, 0);
    addIdle();
    addInstr(6'b111111, 0);
    addInstr(6'b000001, 0);
    addIdle();
    foreach (trace[i]) begin
      stepDut(trace[i], obs, ret, ret2);
      checks += 2;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("[TB] FAIL alu_illegal step %0d outputs: got %b expected %b", i, obs, trace[i].exp);
      end
      if (ret !== modelCnt[15:0] || ret2 !== modelCnt[1:0]) begin
        errors++;
        $display("[TB] FAIL alu_illegal step %0d retired: got %0d/%0d expected %0d", i, ret, ret2, modelCnt);
      end
      if (trace[i].clr) modelCnt = 0; else if (trace[i].retire) modelCnt++;
    end
  endtask

  task automatic test_reset_mid_mem();
    trace.delete();
    addInstr(6'b000000, 0);
    addInstr(6'b100011, -1);
    while (trace.size() > 9) void'(trace.pop_back());
    addReset(); addIdle(); addIdle();
    foreach (trace[i]) begin
      stepDut(trace[i], obs, ret, ret2);
      checks += 2;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("[TB] FAIL reset_mid_mem step %0d outputs: got %b expected %b", i, obs, trace[i].exp);
      end
      if (ret !== modelCnt[15:0] || ret2 !== modelCnt[1:0]) begin
        errors++;
        $display("[TB] FAIL reset_mid_mem step %0d retired: got %0d/%0d expected %0d", i, ret, ret2, modelCnt);
      end
      if (trace[i].clr) modelCnt = 0; else if (trace[i].retire) modelCnt++;
    end
  endtask

  task automatic test_wrap();
    trace.delete();
    addReset(); addIdle();
    for (int n = 0; n < 5; n++) addInstr(($urandom % 2) ? 6'b000010 : 6'b001000, 0);
    addIdle();
    foreach (trace[i]) begin
      stepDut(trace[i], obs, ret, ret2);
      checks += 2;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("[TB] FAIL wrap step %0d outputs: got %b expected %b", i, obs, trace[i].exp);
      end
      if (ret !== modelCnt[15:0] || ret2 !== modelCnt[1:0]) begin
        errors++;
        $display("[TB] FAIL wrap step %0d retired: got %0d/%0d expected %0d", i, ret, ret2, modelCnt);
      end
      if (trace[i].clr) modelCnt = 0; else if (trace[i].retire) modelCnt++;
    end
    checks++;
    if (retiredSmall !== 2'd1 || retired !== 16'd5) begin
      errors++;
      $display("[TB] FAIL wrap final: got %0d/%0d expected 1/5", retiredSmall, retired);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000010, 6'b001000, 6'b000000};
    trace.delete();
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op = ($urandom % 8 == 0) ? 6'($urandom) : ops[$urandom % 6];
      int delay = ($urandom % 5 == 0) ? -1 : int'($urandom_range(0, 9));
      if ($urandom % 3 == 0) addIdle();
      addInstr(op, delay);
    end
    addIdle();
    foreach (trace[i]) begin
      stepDut(trace[i], obs, ret, ret2);
      checks += 2;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("[TB] FAIL random step %0d outputs: got %b expected %b", i, obs, trace[i].exp);
      end
      if (ret !== modelCnt[15:0] || ret2 !== modelCnt[1:0]) begin
        errors++;
        $display("[TB] FAIL random step %0d retired: got %0d/%0d expected %0d", i, ret, ret2, modelCnt);
      end
      if (trace[i].clr) modelCnt = 0; else if (trace[i].retire) modelCnt++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_alu_illegal();
    test_reset_mid_mem();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
